// File: rtl/sub32_serial.sv
// Digit-serial 32-bit subtractor: d = a - b - bi, DIGIT bits per cycle, LSB digit first.
// Latency 32/DIGIT cycles from accepted start to done; start only taken while ready, never queued.
module sub32_serial #(
   parameter int DIGIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        bi,
   output logic        ready,
   output logic        busy,
   output logic        done,
   output logic [31:0] d,
   output logic        bo,
   output logic        v,
   output logic        z
);
   localparam int N  = 32 / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [31:0]      a_r, b_r, d_wrk, d_nxt;
   logic             borrow, borrow_nxt;
   logic [DIGIT-1:0] a_dig, b_dig;
   logic [DIGIT:0]   dig_sub;
   logic             accept, last;

   assign accept = start && (state != S_RUN);
   assign last   = (state == S_RUN) && (cnt == LAST);

   // One digit of the borrow chain; the extra top bit of the difference is the borrow out.
   always_comb begin
      a_dig      = a_r[int'(cnt)*DIGIT +: DIGIT];
      b_dig      = b_r[int'(cnt)*DIGIT +: DIGIT];
      dig_sub    = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, borrow};
      borrow_nxt = dig_sub[DIGIT];
      d_nxt      = d_wrk;
      d_nxt[int'(cnt)*DIGIT +: DIGIT] = dig_sub[DIGIT-1:0];
   end

   always_comb begin
      state_nxt = state;
      ready     = 1'b1;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_RUN;
         end
         S_RUN: begin
            ready = 1'b0;
            busy  = 1'b1;
            if (cnt == LAST) state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = start ? S_RUN : S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r    <= '0;
         b_r    <= '0;
         borrow <= 1'b0;
         cnt    <= '0;
         d_wrk  <= '0;
         d      <= '0;
         bo     <= 1'b0;
         v      <= 1'b0;
         z      <= 1'b0;
      end else begin
         if (accept) begin
            a_r    <= a;
            b_r    <= b;
            borrow <= bi;
            cnt    <= '0;
            d_wrk  <= '0;
         end else if (state == S_RUN) begin
            d_wrk  <= d_nxt;
            borrow <= borrow_nxt;
            cnt    <= last ? '0 : cnt + 1'b1;
         end
         // Visible results change only once, with the final digit folded in.
         if (last) begin
            d  <= d_nxt;
            bo <= borrow_nxt;
            v  <= (a_r[31] ^ b_r[31]) & (d_nxt[31] ^ a_r[31]);
            z  <= (d_nxt == 32'd0);
         end
      end
   end

endmodule

// File: tb/tb_sub32_serial.sv
// Bench for sub32_serial: three instances (DIGIT 4, 1, 32) checked against an arithmetic reference model.
module tb_sub32_serial;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  start = '0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        bi = 1'b0;

   logic        ready_o [3];
   logic        busy_o  [3];
   logic        done_o  [3];
   logic [31:0] d_o     [3];
   logic        bo_o    [3];
   logic        v_o     [3];
   logic        z_o     [3];

   int total  = 0;
   int passed = 0;
   int nn [3] = '{8, 32, 1};

   always #5 clk = ~clk;

   sub32_serial #(.DIGIT(4)) u_d4 (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .a(a), .b(b), .bi(bi),
      .ready(ready_o[0]), .busy(busy_o[0]), .done(done_o[0]),
      .d(d_o[0]), .bo(bo_o[0]), .v(v_o[0]), .z(z_o[0]));

   sub32_serial #(.DIGIT(1)) u_d1 (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .a(a), .b(b), .bi(bi),
      .ready(ready_o[1]), .busy(busy_o[1]), .done(done_o[1]),
      .d(d_o[1]), .bo(bo_o[1]), .v(v_o[1]), .z(z_o[1]));

   sub32_serial #(.DIGIT(32)) u_d32 (
      .clk(clk), .rst_n(rst_n), .start(start[2]), .a(a), .b(b), .bi(bi),
      .ready(ready_o[2]), .busy(busy_o[2]), .done(done_o[2]),
      .d(d_o[2]), .bo(bo_o[2]), .v(v_o[2]), .z(z_o[2]));

   task automatic chk(input string tag, input string field, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s.%s: observed %0h expected %0h", tag, field, obs, exp);
   endtask

   // Reference: unsigned compare for borrow, signed range test for overflow.
   task automatic model(input logic [31:0] ta, input logic [31:0] tb_, input logic tbi,
                        output logic [31:0] ed, output logic ebo, output logic ev,
                        output logic ez);
      longint sr;
      ed  = ta - tb_ - 32'(tbi);
      ebo = ({1'b0, ta} < ({1'b0, tb_} + 33'(tbi)));
      sr  = longint'($signed(ta)) - longint'($signed(tb_)) - longint'(tbi);
      ev  = (sr < -64'sd2147483648) || (sr > 64'sd2147483647);
      ez  = (ed == 32'd0);
   endtask

   task automatic launch(input int k, input logic [31:0] ta, input logic [31:0] tb_,
                         input logic tbi);
      @(negedge clk);
      a = ta; b = tb_; bi = tbi;
      start[k] = 1'b1;
      @(negedge clk);
      start[k] = 1'b0;
   endtask

   task automatic wait_done(input int k, output int lat, output int bcnt, output logic ok);
      lat = 0; bcnt = 0; ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (done_o[k]) begin
            ok = 1'b1;
            break;
         end
         if (busy_o[k]) bcnt++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic do_op(input int k, input logic [31:0] ta, input logic [31:0] tb_,
                        input logic tbi, input string tag);
      logic [31:0] prev, ed;
      logic        ebo, ev, ez, ok;
      int          lat, bcnt;
      model(ta, tb_, tbi, ed, ebo, ev, ez);
      prev = d_o[k];
      launch(k, ta, tb_, tbi);
      chk(tag, "busy_run", 64'(busy_o[k]), 64'd1);
      chk(tag, "held_d", 64'(d_o[k]), 64'(prev));
      wait_done(k, lat, bcnt, ok);
      chk(tag, "timeout", 64'(ok), 64'd1);
      chk(tag, "latency", 64'(lat), 64'(nn[k]));
      chk(tag, "busy_cycles", 64'(bcnt), 64'(nn[k]));
      chk(tag, "d", 64'(d_o[k]), 64'(ed));
      chk(tag, "bo", 64'(bo_o[k]), 64'(ebo));
      chk(tag, "v", 64'(v_o[k]), 64'(ev));
      chk(tag, "z", 64'(z_o[k]), 64'(ez));
      @(negedge clk);
      chk(tag, "done_pulse", 64'(done_o[k]), 64'd0);
      chk(tag, "d_after", 64'(d_o[k]), 64'(ed));
   endtask

   initial begin
      logic [31:0] ta, tb_, ed;
      logic        tbi, ebo, ev, ez, ok, stable, saw_done;
      int          lat, bcnt, k, gap;

      // Reset state, and start ignored while reset is low at the edge
      start = 3'b111;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk("reset", "ready", 64'(ready_o[i]), 64'd1);
         chk("reset", "busy", 64'(busy_o[i]), 64'd0);
         chk("reset", "done", 64'(done_o[i]), 64'd0);
         chk("reset", "outs", {27'd0, d_o[i], bo_o[i], v_o[i], z_o[i]}, 64'd0);
      end
      start = '0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset", "busy", 64'(busy_o[0]), 64'd0);

      // Directed cases
      do_op(0, 32'd10, 32'd3, 1'b0, "basic_d4");
      do_op(0, 32'd0, 32'd1, 1'b0, "unsigned_borrow");
      do_op(0, 32'h8000_0000, 32'd1, 1'b0, "signed_ovf");
      do_op(0, 32'd5, 32'd4, 1'b1, "bi_zero");
      do_op(0, 32'd0, 32'hFFFF_FFFF, 1'b1, "bi_wrap_zero");

      // start pulse and operand changes during RUN are ignored
      launch(0, 32'd1000, 32'd1, 1'b0);
      repeat (2) @(negedge clk);
      a = 32'd77; start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0; a = 32'd5000; b = 32'd7; bi = 1'b1;
      wait_done(0, lat, bcnt, ok);
      chk("ignore_start", "timeout", 64'(ok), 64'd1);
      chk("ignore_start", "latency", 64'(lat + 3), 64'(nn[0]));
      chk("ignore_start", "d", 64'(d_o[0]), 64'd999);
      @(negedge clk);
      chk("ignore_start", "idle_ready", 64'(ready_o[0]), 64'd1);
      chk("ignore_start", "d_kept", 64'(d_o[0]), 64'd999);

      // start held through DONE: back-to-back results N+1 cycles apart
      a = 32'd20; b = 32'd5; bi = 1'b0; start[0] = 1'b1;
      @(negedge clk);
      a = 32'd50; b = 32'd8;
      wait_done(0, lat, bcnt, ok);
      chk("b2b", "first_timeout", 64'(ok), 64'd1);
      chk("b2b", "first_d", 64'(d_o[0]), 64'd15);
      @(negedge clk);
      start[0] = 1'b0;
      chk("b2b", "rerun_busy", 64'(busy_o[0]), 64'd1);
      gap = 1; stable = 1'b1; ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (done_o[0]) begin
            ok = 1'b1;
            break;
         end
         if (d_o[0] !== 32'd15) stable = 1'b0;
         @(negedge clk);
         gap++;
      end
      chk("b2b", "second_timeout", 64'(ok), 64'd1);
      chk("b2b", "gap", 64'(gap), 64'(nn[0] + 1));
      chk("b2b", "d_stable", 64'(stable), 64'd1);
      chk("b2b", "second_d", 64'(d_o[0]), 64'd42);
      @(negedge clk);

      // Asynchronous reset in the middle of RUN
      launch(0, 32'd123456, 32'd789, 1'b0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_reset", "outs", {27'd0, d_o[0], bo_o[0], v_o[0], z_o[0]}, 64'd0);
      chk("mid_reset", "ready", 64'(ready_o[0]), 64'd1);
      chk("mid_reset", "busy", 64'(busy_o[0]), 64'd0);
      saw_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done_o[0]) saw_done = 1'b1;
         if (i == 2) rst_n = 1'b1;
      end
      chk("mid_reset", "no_done", 64'(saw_done), 64'd0);
      do_op(0, 32'd100, 32'd58, 1'b0, "after_reset");

      // Other digit widths
      do_op(1, 32'd10, 32'd3, 1'b0, "basic_d1");
      do_op(2, 32'd10, 32'd3, 1'b0, "basic_d32");
      do_op(1, 32'h8000_0000, 32'd1, 1'b0, "ovf_d1");
      do_op(2, 32'd0, 32'hFFFF_FFFF, 1'b1, "wrap_d32");

      // Randomized operands against the model
      for (int i = 0; i < 24; i++) begin
         k   = i % 3;
         ta  = $urandom;
         tb_ = $urandom;
         tbi = 1'($urandom_range(0, 1));
         if (i % 5 == 0) tb_ = ta;
         if (i % 7 == 0) tb_ = ta - 32'd1;
         if (i % 4 == 1) ta[31] = ~tb_[31];
         do_op(k, ta, tb_, tbi, $sformatf("rand%0d", i));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/sub32_serial.md
# sub32_serial

Digit-serial 32-bit subtractor with borrow chain, the subtract-direction counterpart to the ripple-carry `adder32` datapath. It computes `a - b - bi` over several clock cycles, processing `DIGIT` bits per cycle from LSB to MSB, and sits beside the adder in the ALU. A start/ready/done handshake controls operation. Results (difference, borrow-out, signed overflow, zero) are registered and held stable until the next completion.

## Interface
- `DIGIT`, default 4: bits processed per cycle. Legal values are 1, 2, 4, 8, 16 and 32; must divide 32. `N = 32/DIGIT` run cycles.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  request a subtraction. Sampled only while `ready`=1.
- `a`  in  32  minuend. Latched on an accepted `start`.
- `b`  in  32  subtrahend. Latched on an accepted `start`.
- `bi`  in  1  borrow-in. Latched on an accepted `start`.
- `ready`  out  1  able to accept `start`.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse: results updated.
- `d`  out  32  difference, `(a - b - bi) mod 2^32`.
- `bo`  out  1  borrow-out: 1 iff `a < b + bi` (unsigned compare).
- `v`  out  1  signed overflow: `(a[31]^b[31]) & (d[31]^a[31])`.
- `z`  out  1  `d == 0`.

## Operation
- **States**
  - IDLE: `ready`=1, `busy`=0.
  - RUN: `ready`=0, `busy`=1. Holds digit counter `cnt`, 0..N-1.
  - DONE: `ready`=1, `busy`=0, `done`=1.
- **Transitions**
  - IDLE→RUN on `start`. Latch `a`, `b` and `bi` into working registers, set `cnt`=0, set the internal borrow to `bi`.
  - RUN: each cycle, subtract digit `cnt` of the latched `b` from digit `cnt` of the latched `a`, including the internal borrow. Write the result digit into the difference shift register and update the internal borrow. At `cnt`=N-1, go to DONE.
  - DONE→RUN if `start`=1, with a fresh operand latch. Otherwise DONE→IDLE.
- **Outputs**
  - `d`, `bo`, `v` and `z` load together on the transition into DONE. They never show partial results.
  - They hold their values through IDLE and RUN until the next DONE.
- **Ignored inputs**
  - `start` while `busy`=1 is ignored. No queuing.
  - Changes on `a`, `b` or `bi` during RUN have no effect.
- **Width rules**
  - All arithmetic is modulo 2^32.
  - `bo` is the borrow out of bit 31.
  - `v` uses the final `d` and the latched `a` and `b`.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - state=IDLE, `ready`=1, `busy`=0, `done`=0.
  - `d`=0, `bo`=0, `v`=0, `z`=0.
  - Internal counter, borrow and working registers cleared.
- Reset asserted mid-RUN: the operation is abandoned immediately and no `done` is produced. Release returns to IDLE, and the next `start` works normally.
- Latency:
  - `start` sampled at edge E0 → RUN at edges E1..EN.
  - `done`=1 and results valid in the cycle following edge EN, i.e. N cycles after the accepting edge.
  - DIGIT=4 gives 8 cycles; DIGIT=32 gives 1 cycle.
- `done` is high for exactly one cycle per accepted `start`.
- Throughput: `start` held high from DONE gives one result every N+1 cycles.
- `start` and reset deassertion in the same cycle: `start` is ignored if `rst_n` is low at the edge.

## Test plan
- **Basic:** `a`=10, `b`=3, `bi`=0, DIGIT=4.
  - `done` appears 8 cycles after the start edge.
  - `d`=7, `bo`=0, `v`=0, `z`=0.
  - `busy`=1 for exactly 8 cycles.
- **Unsigned borrow:** `a`=0, `b`=1.
  - `d`=0xFFFFFFFF, `bo`=1, `v`=0, `z`=0.
- **Signed overflow:** `a`=0x80000000, `b`=1.
  - `d`=0x7FFFFFFF, `bo`=0, `v`=1.
- **Borrow-in and zero:** `a`=5, `b`=4, `bi`=1 → `d`=0, `z`=1, `bo`=0.
  - Also `a`=0, `b`=0xFFFFFFFF, `bi`=1 → `d`=0, `bo`=1, `z`=1.
- **Handshake:**
  - Pulse `start` again at RUN cycle 3 with different `a`. It is ignored and the first result is unchanged.
  - Hold `start` high through DONE. The second `done` arrives 9 cycles after the first.
  - `d` stays stable between the two `done` pulses.
- **Reset mid-op:**
  - Assert `rst_n`=0 at RUN cycle 4. All outputs go to 0 and `ready`=1 asynchronously, with no `done`.
  - After release, run `a`=100, `b`=58 → `d`=42.
  - Repeat the basic case with DIGIT=1 (`done` after 32 cycles) and DIGIT=32 (`done` after 1 cycle).
